// File: rtl/uart_dbg_pkg.sv
// Shared constants and state encoding for the UART debug bridge.
package uart_dbg_pkg;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam int unsigned PAYLOAD_W = 40;
  localparam int unsigned NBYTES_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS,
    SEND,
    SEND_WAIT_START,
    SEND_WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_byte_sender.sv
// Streams 1..5 bytes of a payload (LSB first) through the UART transmit handshake.
module uart_byte_sender
  import uart_dbg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NBYTES_W-1:0]  nbytes,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 is_transmitting,
  output logic [7:0]           tx_byte,
  output logic                 transmit,
  output logic                 done
);

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] buf_q, buf_d, src_buf;
  logic [NBYTES_W-1:0]  left_q, left_d, src_left;
  logic [7:0]           tx_byte_d;
  logic                 transmit_d, done_d, can_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      left_q   <= '0;
      tx_byte  <= '0;
      transmit <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      left_q   <= left_d;
      tx_byte  <= tx_byte_d;
      transmit <= transmit_d;
      done     <= done_d;
    end
  end

  // A start with an idle UART fires the first byte on the same edge.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    left_d     = left_q;
    tx_byte_d  = tx_byte;
    transmit_d = 1'b0;
    done_d     = 1'b0;
    src_buf    = buf_q;
    src_left   = left_q;
    can_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_buf  = payload;
          src_left = nbytes;
          buf_d    = payload;
          left_d   = nbytes;
          state_d  = SEND;
          can_fire = 1'b1;
        end
      end
      SEND: can_fire = 1'b1;
      SEND_WAIT_START: begin
        if (is_transmitting) state_d = SEND_WAIT_DONE;
      end
      SEND_WAIT_DONE: begin
        if (!is_transmitting) begin
          if (left_q != '0) begin
            state_d = SEND;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (can_fire && !is_transmitting) begin
      tx_byte_d  = src_buf[7:0];
      buf_d      = src_buf >> 8;
      left_d     = src_left - NBYTES_W'(1);
      transmit_d = 1'b1;
      state_d    = SEND_WAIT_START;
    end
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// Host debug responder: decodes UART command frames into single 32-bit bus reads/writes
// and returns status plus read data over the UART.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 1_000_000,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        received,
  input  logic        recv_error,
  input  logic        is_transmitting,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy
);

  localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam int unsigned BUS_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_TIMEOUT);
  localparam logic [BUS_W-1:0] BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 is_write_q, is_write_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [BUS_W-1:0]     bus_cnt_q, bus_cnt_d;
  logic                 bus_req_d, bus_we_d;
  logic [31:0]          bus_addr_d, bus_wdata_d;
  logic                 snd_start_c, snd_done;
  logic [NBYTES_W-1:0]  snd_nbytes_c;
  logic [PAYLOAD_W-1:0] snd_payload_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      gap_q      <= '0;
      bus_cnt_q  <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      gap_q      <= gap_d;
      bus_cnt_q  <= bus_cnt_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      busy       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_write_d    = is_write_q;
    gap_d         = gap_q;
    bus_cnt_d     = bus_cnt_q;
    bus_req_d     = bus_req;
    bus_we_d      = bus_we;
    bus_addr_d    = bus_addr;
    bus_wdata_d   = bus_wdata;
    snd_start_c   = 1'b0;
    snd_nbytes_c  = NBYTES_W'(1);
    snd_payload_c = {32'd0, RSP_NAK};
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (!recv_error && received) begin
          if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
            is_write_d = (rx_byte == CMD_WRITE);
            cnt_d      = '0;
            state_d    = GET_ADDR;
          end else begin
            snd_start_c = 1'b1;
            state_d     = SEND;
          end
        end
      end
      // Little-endian fields shift in from the top; four bytes fill the word.
      GET_ADDR, GET_DATA: begin
        if (recv_error) begin
          state_d = IDLE;
        end else if (received) begin
          gap_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == GET_ADDR) bus_addr_d  = {rx_byte, bus_addr[31:8]};
          else                     bus_wdata_d = {rx_byte, bus_wdata[31:8]};
          if (cnt_q == 2'd3) begin
            if (state_q == GET_ADDR && is_write_q) begin
              state_d = GET_DATA;
            end else begin
              state_d   = BUS;
              bus_req_d = 1'b1;
              bus_we_d  = is_write_q;
              bus_cnt_d = '0;
            end
          end
        end else if (gap_q >= GAP_LIMIT) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      // Ack takes priority over a timeout expiring in the same cycle.
      BUS: begin
        if (bus_ack) begin
          bus_req_d     = 1'b0;
          snd_start_c   = 1'b1;
          snd_nbytes_c  = bus_we ? NBYTES_W'(1) : NBYTES_W'(5);
          snd_payload_c = bus_we ? {32'd0, RSP_ACK} : {bus_rdata, RSP_ACK};
          state_d       = SEND;
        end else if (bus_cnt_q >= BUS_LAST) begin
          bus_req_d   = 1'b0;
          snd_start_c = 1'b1;
          state_d     = SEND;
        end else begin
          bus_cnt_d = bus_cnt_q + BUS_W'(1);
        end
      end
      SEND: begin
        if (snd_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  uart_byte_sender u_sender (
    .clk             (clk),
    .rst             (rst),
    .start           (snd_start_c),
    .nbytes          (snd_nbytes_c),
    .payload         (snd_payload_c),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .done            (snd_done)
  );

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Self-checking bench for uart_dbg_bridge with UART and bus-slave models and a memory reference model.
module tb_uart_dbg_bridge;

  typedef logic [7:0] byte_q_t[$];

  localparam int unsigned GAP_TO = 100;
  localparam int unsigned BUS_TO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        received = 1'b0;
  logic        recv_error = 1'b0;
  logic        is_transmitting = 1'b0;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_dbg_bridge #(.GAP_TIMEOUT(GAP_TO), .BUS_TIMEOUT(BUS_TO)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received), .recv_error(recv_error),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy)
  );

  // UART transmitter model: logs bytes, stays busy a random time, flags protocol abuse.
  logic [7:0] tx_log [0:4095];
  int tx_n = 0, tx_viol = 0, tx_left = 0;
  always @(negedge clk) begin
    if (rst) begin
      is_transmitting = 1'b0;
      tx_left = 0;
    end else begin
      if (is_transmitting && tx_byte !== tx_log[tx_n-1]) tx_viol++;
      if (transmit && is_transmitting) tx_viol++;
      if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) is_transmitting = 1'b0;
      end
      if (transmit) begin
        tx_log[tx_n] = tx_byte;
        tx_n++;
        is_transmitting = 1'b1;
        tx_left = $urandom_range(2, 6);
      end
    end
  end

  // Bus slave: memory defaulting to ~addr, random ack latency, plus test-requested manual acks.
  logic [31:0] mem [logic [31:0]];
  logic        txn_we    [0:255];
  logic [31:0] txn_addr  [0:255];
  logic [31:0] txn_wdata [0:255];
  int txn_n = 0, req_cycles = 0, ack_wait = 0;
  int man_ack_req = 0, man_ack_done = 0;
  logic [31:0] man_rdata = '0;
  bit ack_en = 1'b0;
  always @(negedge clk) begin
    bus_ack = 1'b0;
    if (bus_req) req_cycles++;
    if (man_ack_req != man_ack_done) begin
      bus_ack = 1'b1;
      bus_rdata = man_rdata;
      man_ack_done++;
    end else if (!rst && bus_req && ack_en) begin
      if (ack_wait == 0) begin
        bus_ack = 1'b1;
        txn_we[txn_n] = bus_we;
        txn_addr[txn_n] = bus_addr;
        txn_wdata[txn_n] = bus_wdata;
        txn_n++;
        if (bus_we) mem[bus_addr] = bus_wdata;
        else bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : ~bus_addr;
        ack_wait = $urandom_range(0, 5);
      end else begin
        ack_wait--;
      end
    end
    if (!bus_req) ack_wait = $urandom_range(0, 5);
  end

  // Reference model: what the host expects memory to hold.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  function automatic byte_q_t rd_frame(input logic [31:0] a);
    byte_q_t q;
    q.push_back(8'h52);
    for (int k = 0; k < 4; k++) q.push_back(8'(a >> (8 * k)));
    return q;
  endfunction

  function automatic byte_q_t wr_frame(input logic [31:0] a, input logic [31:0] d);
    byte_q_t q;
    q.push_back(8'h57);
    for (int k = 0; k < 4; k++) q.push_back(8'(a >> (8 * k)));
    for (int k = 0; k < 4; k++) q.push_back(8'(d >> (8 * k)));
    return q;
  endfunction

  function automatic byte_q_t ack_rsp(input bit with_data, input logic [31:0] d);
    byte_q_t q;
    q.push_back(8'h06);
    if (with_data) for (int k = 0; k < 4; k++) q.push_back(8'(d >> (8 * k)));
    return q;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    received = 1'b1;
    @(posedge clk);
    #1 received = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t fr, input int gap_max);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (i != fr.size() - 1) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_idle(output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 3000) begin
      if (busy === 1'b0) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        i++;
      end
    end
  endtask

  // True when the bytes logged since t0 exactly equal exp.
  function automatic bit rsp_match(input int t0, input byte_q_t exp);
    if (tx_n - t0 != exp.size()) return 1'b0;
    for (int k = 0; k < exp.size(); k++) if (tx_log[t0 + k] !== exp[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({transmit, tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%b txb=%h req=%b we=%b addr=%h wdata=%h busy=%b, want all zero",
               transmit, tx_byte, bus_req, bus_we, bus_addr, bus_wdata, busy);
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b req=%b, want 0 0", busy, bus_req);
    end
  endtask

  task automatic test_read();
    int t0;
    bit ok;
    ack_en = 1'b0;
    t0 = tx_n;
    send_frame(rd_frame(32'h8000_0010), 2);
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h8000_0010) begin
      errors++;
      $display("FAIL read_request: got req=%b we=%b addr=%h, want 1 0 80000010", bus_req, bus_we, bus_addr);
    end
    idle(3);
    man_rdata = 32'hDEAD_BEEF;
    man_ack_req++;
    @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || transmit !== 1'b1) begin
      errors++;
      $display("FAIL read_ack_timing: got req=%b transmit=%b, want 0 1", bus_req, transmit);
    end
    wait_idle(ok);
    checks++;
    if (!ok || !rsp_match(t0, ack_rsp(1'b1, 32'hDEAD_BEEF))) begin
      errors++;
      $display("FAIL read_response: got %0d bytes (idle=%b) first %h, want 06 EF BE AD DE", tx_n - t0, ok, tx_log[t0]);
    end
  endtask

  task automatic test_write();
    int t0;
    bit ok;
    ack_en = 1'b1;
    t0 = tx_n;
    send_frame(wr_frame(32'h0000_0004, 32'h1234_5678), 2);
    ref_mem[32'h4] = 32'h1234_5678;
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h4 || bus_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_request: got req=%b we=%b addr=%h wdata=%h, want 1 1 00000004 12345678",
               bus_req, bus_we, bus_addr, bus_wdata);
    end
    wait_idle(ok);
    checks++;
    if (!ok || !rsp_match(t0, ack_rsp(1'b0, 32'h0))) begin
      errors++;
      $display("FAIL write_response: got %0d bytes (idle=%b) first %h, want 06", tx_n - t0, ok, tx_log[t0]);
    end
  endtask

  task automatic test_bad_opcode();
    int t0, r0;
    bit ok;
    byte_q_t fr, exp;
    t0 = tx_n;
    r0 = req_cycles;
    fr.push_back(8'hAA);
    exp.push_back(8'h15);
    send_frame(fr, 0);
    wait_idle(ok);
    checks++;
    if (!ok || !rsp_match(t0, exp) || req_cycles != r0) begin
      errors++;
      $display("FAIL bad_opcode: got %0d bytes first %h req_cycles %0d, want 15 and 0 req cycles",
               tx_n - t0, tx_log[t0], req_cycles - r0);
    end
  endtask

  task automatic test_bus_timeout();
    int t0, hi;
    bit ok;
    byte_q_t exp;
    ack_en = 1'b0;
    t0 = tx_n;
    exp.push_back(8'h15);
    send_frame(rd_frame(32'h0000_0F00), 1);
    hi = 0;
    while (bus_req === 1'b1 && hi < 2000) begin
      hi++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (hi != BUS_TO) begin
      errors++;
      $display("FAIL bus_timeout_len: got %0d cycles of bus_req, want %0d", hi, BUS_TO);
    end
    wait_idle(ok);
    checks++;
    if (!ok || !rsp_match(t0, exp)) begin
      errors++;
      $display("FAIL bus_timeout_rsp: got %0d bytes first %h, want 15", tx_n - t0, tx_log[t0]);
    end
  endtask

  task automatic test_gap_timeout();
    int t0;
    bit ok;
    byte_q_t fr;
    t0 = tx_n;
    fr.push_back(8'h52);
    fr.push_back(8'h10);
    send_frame(fr, 0);
    idle(50);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_still_busy: got busy=%b, want 1", busy);
    end
    idle(60);
    checks++;
    if (busy !== 1'b0 || tx_n != t0) begin
      errors++;
      $display("FAIL gap_abort: got busy=%b bytes=%0d, want 0 0", busy, tx_n - t0);
    end
    ack_en = 1'b1;
    send_frame(rd_frame(32'h0000_0300), 2);
    wait_idle(ok);
    checks++;
    if (!ok || !rsp_match(t0, ack_rsp(1'b1, ref_read(32'h300)))) begin
      errors++;
      $display("FAIL gap_followup_read: got %0d bytes first %h, want 5 bytes of 06+%h",
               tx_n - t0, tx_log[t0], ref_read(32'h300));
    end
  endtask

  task automatic test_recv_error();
    int r0;
    byte_q_t fr;
    r0 = req_cycles;
    fr.push_back(8'h57);
    fr.push_back(8'h01);
    fr.push_back(8'h02);
    send_frame(fr, 1);
    recv_error = 1'b1;
    @(posedge clk);
    #1 recv_error = 1'b0;
    checks++;
    if (busy !== 1'b0 || req_cycles != r0) begin
      errors++;
      $display("FAIL recv_error_abort: got busy=%b req_cycles=%0d, want 0 0", busy, req_cycles - r0);
    end
  endtask

  task automatic test_reset_mid_bus();
    int t0;
    ack_en = 1'b0;
    t0 = tx_n;
    send_frame(rd_frame(32'h0000_0040), 2);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_bus_req_rise: got req=%b, want 1", bus_req);
    end
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_bus_reset: got req=%b busy=%b, want 0 0", bus_req, busy);
    end
    rst = 1'b0;
    man_rdata = 32'h1111_2222;
    man_ack_req++;
    idle(20);
    checks++;
    if (tx_n != t0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored: got bytes=%0d busy=%b, want 0 0", tx_n - t0, busy);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t fr, exp;
    logic [31:0] a, d;
    logic [7:0] b;
    int op, t0, x0;
    bit ok, is_wr;
    ack_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
      d = $urandom;
      is_wr = (op <= 1);
      fr.delete();
      exp.delete();
      if (is_wr) begin
        fr = wr_frame(a, d);
        ref_mem[a] = d;
        exp = ack_rsp(1'b0, 32'h0);
      end else if (op <= 3) begin
        fr = rd_frame(a);
        exp = ack_rsp(1'b1, ref_read(a));
      end else begin
        do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
        fr.push_back(b);
        exp.push_back(8'h15);
      end
      t0 = tx_n;
      x0 = txn_n;
      send_frame(fr, 3);
      wait_idle(ok);
      checks++;
      if (!ok || !rsp_match(t0, exp)) begin
        errors++;
        $display("FAIL b2b_response #%0d op=%0d addr=%h: got %0d bytes first %h, want %0d bytes first %h",
                 n, op, a, tx_n - t0, tx_log[t0], exp.size(), exp[0]);
      end
      if (op <= 3) begin
        checks++;
        if (txn_n != x0 + 1 || txn_we[x0] !== is_wr || txn_addr[x0] !== a || (is_wr && txn_wdata[x0] !== d)) begin
          errors++;
          $display("FAIL b2b_bus_txn #%0d: got n=%0d we=%b addr=%h wdata=%h, want n=1 we=%b addr=%h wdata=%h",
                   n, txn_n - x0, txn_we[x0], txn_addr[x0], txn_wdata[x0], is_wr, a, d);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_read();
    test_write();
    test_bad_opcode();
    test_bus_timeout();
    test_gap_timeout();
    test_recv_error();
    test_reset_mid_bus();
    test_back_to_back();
    checks++;
    if (tx_viol != 0) begin
      errors++;
      $display("FAIL tx_protocol: got %0d handshake violations, want 0", tx_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

Host-facing debug responder on the byte side of the UART. It decodes command frames arriving as `rx_byte`/`received` pulses and executes single 32-bit read or write transactions on a simple request/acknowledge memory bus. It returns status and read data through the UART's `transmit`/`tx_byte` interface. It gives an external host direct memory access to the on-chip system.

## Interface
- `GAP_TIMEOUT`, default 1_000_000: maximum idle clk cycles between bytes of one frame; on expiry the frame is aborted.
- `BUS_TIMEOUT`, default 1024: maximum clk cycles `bus_req` stays high without `bus_ack`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_byte`  in  8  received byte; valid while `received`=1.
- `received`  in  1  one-cycle pulse per received byte.
- `recv_error`  in  1  one-cycle pulse on framing error.
- `is_transmitting`  in  1  UART transmitter busy.
- `tx_byte`  out  8  byte to send; held stable from the `transmit` pulse until `is_transmitting` falls.
- `transmit`  out  1  one-cycle send request.
- `bus_req`  out  1  transaction request; held until `bus_ack` or timeout.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  32  byte address.
- `bus_wdata`  out  32  write data.
- `bus_rdata`  in  32  read data; valid while `bus_ack`=1.
- `bus_ack`  in  1  one-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Frame format, multi-byte fields little-endian:
  - Read: `0x52`, then addr[4].
  - Write: `0x57`, then addr[4], then data[4].
- Responses:
  - Read success: `0x06`, then rdata[4], LSB first.
  - Write success: `0x06`.
  - Unknown opcode or bus timeout: `0x15`.
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS, SEND, SEND_WAIT_START, SEND_WAIT_DONE.
- IDLE: on `received`, latch the opcode.
  - Valid opcode: go to GET_ADDR.
  - Invalid opcode: queue `0x15` and go to SEND.
- GET_ADDR / GET_DATA: a 2-bit byte counter shifts bytes into `bus_addr` / `bus_wdata`.
  - After the 4th address byte, a read goes to BUS and a write goes to GET_DATA.
  - After the 4th data byte, go to BUS.
- BUS: assert `bus_req`, with `bus_we`, `bus_addr` and `bus_wdata` stable.
  - On `bus_ack`: drop `bus_req`, capture `bus_rdata`, queue `0x06` (plus 4 data bytes for a read), go to SEND.
  - On timeout: drop `bus_req`, queue `0x15`, go to SEND.
- SEND: if `is_transmitting`=0, pulse `transmit` with `tx_byte` = next byte, then go to SEND_WAIT_START.
- SEND_WAIT_START: wait for `is_transmitting`=1, then go to SEND_WAIT_DONE.
- SEND_WAIT_DONE: wait for `is_transmitting`=0.
  - Bytes remaining: return to SEND.
  - Otherwise: go to IDLE.
- Gap counter: reset on each `received`; counts only in GET_ADDR/GET_DATA. On reaching GAP_TIMEOUT, go silently to IDLE (no response).
- `recv_error` in IDLE/GET_ADDR/GET_DATA: silently go to IDLE. Ignored in other states.
- `received` in BUS/SEND*: byte is dropped.

## Timing
- Reset values: `transmit`=0, `tx_byte`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `busy`=0; FSM in IDLE; all counters 0.
- Reset mid-operation clears everything on the same edge, including an in-flight `bus_req`. A late `bus_ack` after reset is ignored.
- Last frame byte `received` at cycle N: `bus_req`=1 at N+1.
- `bus_ack` at cycle M: `bus_req`=0 and `transmit`=1 at M+1.
- `bus_ack` in the same cycle the bus timeout expires: the ack wins.
- Bus timeout: `bus_req` falls exactly BUS_TIMEOUT cycles after rising.
- Between consecutive `transmit` pulses there is at least one cycle with `is_transmitting`=0.
- Bus counter saturates. Gap counter is width clog2(GAP_TIMEOUT+1) and never wraps.

## Structure
- Package `uart_dbg_pkg`:
  - opcode constants `CMD_READ`=0x52, `CMD_WRITE`=0x57;
  - status constants `RSP_ACK`=0x06, `RSP_NAK`=0x15;
  - FSM state enum.
- Sub-module `uart_byte_sender`: owns the SEND/WAIT_START/WAIT_DONE handshake. Interface:
  - in: `start`, `nbytes` (1..5), 40-bit payload;
  - out: `done` pulse.

## Test plan
- Read: send 52 10 00 00 80; bus acks with 0xDEADBEEF -> `bus_addr`=0x80000010, `bus_we`=0; host receives 06 EF BE AD DE.
- Write: send 57 04 00 00 00 78 56 34 12 -> `bus_we`=1, `bus_wdata`=0x12345678; host receives 06.
- Bad opcode: send 0xAA -> host receives 15; no `bus_req`.
- Bus timeout: read with no ack -> `bus_req` drops after 1024 cycles; host receives 15.
- Gap timeout with GAP_TIMEOUT=100: send 52 10, then wait 101 cycles -> `busy`=0. A following full read frame executes correctly.
- Reset mid-BUS state -> `bus_req`=0 on the next edge; a late `bus_ack` produces no transmit.
